// File: rtl/alu_pkg.sv
// Shared types and helpers for the push-button ALU operation controller.
// Holds the opcode type, ALU flag encodings and the controller FSM state enum.
package alu_pkg;

  typedef logic [3:0] opcode_t;

  localparam logic [3:0] FLAG_CARRY = 4'b0001;
  localparam logic [3:0] FLAG_ZERO  = 4'b0010;
  localparam logic [3:0] FLAG_NEG   = 4'b0100;
  localparam logic [3:0] FLAG_OVF   = 4'b1000;
  localparam logic [3:0] FLAG_MASK  = FLAG_CARRY | FLAG_ZERO | FLAG_NEG | FLAG_OVF;

  // All buttons released (active-low board buttons)
  localparam logic [3:0] BTN_RELEASED = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

  function automatic logic single_press(input logic [3:0] btn_n);
    int zeros;
    zeros = 0;
    for (int i = 0; i < 4; i++) begin
      if (!btn_n[i]) zeros++;
    end
    return (zeros == 1);
  endfunction

  function automatic logic [1:0] press_idx(input logic [3:0] btn_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!btn_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus per-vector debounce for raw board push-buttons.
// The debounced vector follows the synchronized one only after it has held a new value long enough.
module btn_debounce #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] sync,
  output logic [W-1:0] deb
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic [W-1:0]     sync_p0;
  logic [W-1:0]     sync_last;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // A change of the synchronized value starts a fresh run of length one
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (sync != sync_last) cnt_nxt = CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0   <= '1;
      sync      <= '1;
      sync_last <= '1;
      deb       <= '1;
      cnt       <= '0;
    end else begin
      sync_p0   <= raw;
      sync      <= sync_p0;
      sync_last <= sync;
      if (sync == deb) begin
        cnt <= '0;
      end else if (cnt_nxt == CNT_W'(DEBOUNCE_CYCLES)) begin
        deb <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt_nxt;
      end
    end
  end

endmodule

// File: rtl/alu_op_controller.sv
// Turns debounced push-button presses into single ALU operations and holds the
// last result, flags and opcode for the display decoders.
module alu_op_controller
  import alu_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   buttons_n,
  input  logic [1:0]   mode,
  input  logic [N-1:0] a_sw,
  input  logic [N-1:0] b_sw,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  output logic         alu_start,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic [N-1:0] result_q,
  output logic [3:0]   flags_q,
  output logic [3:0]   op_q,
  output logic         done,
  output logic         busy,
  output logic         err
);

  logic [3:0] btn_sync;
  logic [3:0] btn_deb;
  logic [3:0] deb_prev;
  logic [1:0] settle;
  logic       armed;
  logic       press_edge;
  logic       press_ok;
  logic       press_multi;
  state_t     state;

  btn_debounce #(
    .W              (4),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (buttons_n),
    .sync (btn_sync),
    .deb  (btn_deb)
  );

  // A button held through reset keeps armed low until everything is seen released
  assign press_edge  = armed && (deb_prev == BTN_RELEASED) && (btn_deb != BTN_RELEASED);
  assign press_ok    = press_edge && single_press(btn_deb);
  assign press_multi = press_edge && !single_press(btn_deb);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      deb_prev  <= BTN_RELEASED;
      settle    <= 2'd0;
      armed     <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 4'b0000;
      alu_start <= 1'b0;
      result_q  <= '0;
      flags_q   <= 4'b0000;
      op_q      <= 4'b0000;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      deb_prev  <= btn_deb;
      alu_start <= 1'b0;
      done      <= 1'b0;
      if (settle != 2'd2) settle <= settle + 2'd1;
      if (settle == 2'd2 && btn_sync == BTN_RELEASED && btn_deb == BTN_RELEASED)
        armed <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (press_ok) begin
            alu_a     <= a_sw;
            alu_b     <= b_sw;
            alu_op    <= {mode, press_idx(btn_deb)};
            alu_start <= 1'b1;
            busy      <= 1'b1;
            err       <= 1'b0;
            state     <= ST_ISSUE;
          end else if (press_multi) begin
            err <= 1'b1;
          end
        end
        // Result is sampled on the ISSUE exit edge so done and the held
        // values appear together during CAPTURE
        ST_ISSUE: begin
          result_q <= alu_result;
          flags_q  <= alu_flags & FLAG_MASK;
          op_q     <= alu_op;
          done     <= 1'b1;
          state    <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (btn_deb == BTN_RELEASED) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
